// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-requester memory request arbiter.
package mem_arb_pkg;

  localparam int unsigned BEATS_PER_LINE_DEFAULT = 4;
  localparam int unsigned DATA_W                 = 128;
  localparam int unsigned WR_BIT                 = 127;
  localparam int unsigned ADDR_MSB               = 31;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } req_state_e;

endpackage

// File: rtl/owner_fifo.sv
// Tracks which requester owns each outstanding read, in issue order.
module owner_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  logic i_push_id,
  input  logic i_pop,
  output logic o_head_id,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head_id = r_mem[r_rd_ptr];

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging two packetised request streams onto one memory port and
// routing in-order read responses back to the requester that issued them.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TAG_DEPTH      = 4,
  parameter int unsigned BEATS_PER_LINE = BEATS_PER_LINE_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              s0_req_axis_valid,
  output logic              s0_req_axis_ready,
  input  logic              s0_req_axis_tuser,
  input  logic [DATA_W-1:0] s0_req_axis_data,
  input  logic              s1_req_axis_valid,
  output logic              s1_req_axis_ready,
  input  logic              s1_req_axis_tuser,
  input  logic [DATA_W-1:0] s1_req_axis_data,
  output logic              m_req_axis_valid,
  input  logic              m_req_axis_ready,
  output logic              m_req_axis_tuser,
  output logic [DATA_W-1:0] m_req_axis_data,
  input  logic              m_resp_axis_valid,
  output logic              m_resp_axis_ready,
  input  logic              m_resp_axis_tuser,
  input  logic [DATA_W-1:0] m_resp_axis_data,
  output logic              s0_resp_axis_valid,
  input  logic              s0_resp_axis_ready,
  output logic              s0_resp_axis_tuser,
  output logic [DATA_W-1:0] s0_resp_axis_data,
  output logic              s1_resp_axis_valid,
  input  logic              s1_resp_axis_ready,
  output logic              s1_resp_axis_tuser,
  output logic [DATA_W-1:0] s1_resp_axis_data,
  output logic              protocol_err_out
);

  localparam int unsigned    BCW        = $clog2(BEATS_PER_LINE + 1);
  localparam logic [BCW-1:0] LINE_BEATS = BCW'(BEATS_PER_LINE);
  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(BEATS_PER_LINE - 1);
  localparam logic [BCW-1:0] ONE_BEAT   = BCW'(1);

  req_state_e       r_state;
  req_state_e       w_state_nxt;
  logic             r_owner;
  logic             r_last_grant;
  logic             r_prot_err;
  logic [BCW-1:0]   r_beat_cnt;
  logic [BCW-1:0]   r_resp_cnt;

  logic              w_cand0;
  logic              w_cand1;
  logic              w_bad0;
  logic              w_bad1;
  logic              w_any_cand;
  logic              w_grant;
  logic              w_own_valid;
  logic              w_own_tuser;
  logic [DATA_W-1:0] w_own_data;
  logic              w_is_hdr;
  logic              w_rd_hdr;
  logic              w_blocked;
  logic              w_req_hs;
  logic              w_burst_done;
  logic              w_push;
  logic              w_pop;
  logic              w_resp_hs;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_head;

  assign w_cand0    = s0_req_axis_valid & s0_req_axis_tuser;
  assign w_cand1    = s1_req_axis_valid & s1_req_axis_tuser;
  assign w_bad0     = s0_req_axis_valid & ~s0_req_axis_tuser;
  assign w_bad1     = s1_req_axis_valid & ~s1_req_axis_tuser;
  assign w_any_cand = w_cand0 | w_cand1;
  assign w_grant    = (w_cand0 & w_cand1) ? ~r_last_grant : w_cand1;

  assign w_own_valid = r_owner ? s1_req_axis_valid : s0_req_axis_valid;
  assign w_own_tuser = r_owner ? s1_req_axis_tuser : s0_req_axis_tuser;
  assign w_own_data  = r_owner ? s1_req_axis_data  : s0_req_axis_data;

  // A zero beat count inside BURST means the header has not yet been accepted.
  assign w_is_hdr     = (r_beat_cnt == '0);
  assign w_rd_hdr     = w_is_hdr & ~w_own_data[WR_BIT];
  assign w_blocked    = w_rd_hdr & w_fifo_full;
  assign w_req_hs     = m_req_axis_valid & m_req_axis_ready;
  assign w_burst_done = w_req_hs & (w_rd_hdr | (~w_is_hdr & (r_beat_cnt == ONE_BEAT)));
  assign w_push       = w_req_hs & w_rd_hdr;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_any_cand) w_state_nxt = StBurst;
      StBurst: if (w_burst_done) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    m_req_axis_valid  = 1'b0;
    m_req_axis_tuser  = w_own_tuser;
    m_req_axis_data   = w_own_data;
    s0_req_axis_ready = 1'b0;
    s1_req_axis_ready = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Malformed beats are swallowed while idle so they cannot wedge the port.
        s0_req_axis_ready = w_bad0;
        s1_req_axis_ready = w_bad1;
      end
      StBurst: begin
        m_req_axis_valid  = w_own_valid & ~w_blocked;
        s0_req_axis_ready = ~r_owner & m_req_axis_ready & ~w_blocked;
        s1_req_axis_ready = r_owner & m_req_axis_ready & ~w_blocked;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_prot_err   <= 1'b0;
      r_beat_cnt   <= '0;
      r_resp_cnt   <= '0;
    end else begin
      r_prot_err <= (r_state == StIdle) & (w_bad0 | w_bad1);
      if ((r_state == StIdle) && w_any_cand) begin
        r_owner <= w_grant;
      end
      if (w_burst_done) begin
        r_last_grant <= r_owner;
      end
      if (w_req_hs) begin
        if (w_is_hdr) begin
          if (w_own_data[WR_BIT]) r_beat_cnt <= LINE_BEATS;
        end else begin
          r_beat_cnt <= r_beat_cnt - 1'b1;
        end
      end
      if (w_resp_hs) begin
        r_resp_cnt <= w_pop ? '0 : r_resp_cnt + 1'b1;
      end
    end
  end

  owner_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_owner_fifo (
    .i_clk     (clk_in),
    .i_rst_n   (rst_n_in),
    .i_push    (w_push),
    .i_push_id (r_owner),
    .i_pop     (w_pop),
    .o_head_id (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign m_resp_axis_ready  = ~w_fifo_empty & (w_head ? s1_resp_axis_ready : s0_resp_axis_ready);
  assign w_resp_hs          = m_resp_axis_valid & m_resp_axis_ready;
  assign w_pop              = w_resp_hs & (r_resp_cnt == LAST_BEAT);

  assign s0_resp_axis_valid = ~w_fifo_empty & ~w_head & m_resp_axis_valid;
  assign s1_resp_axis_valid = ~w_fifo_empty & w_head & m_resp_axis_valid;
  assign s0_resp_axis_tuser = m_resp_axis_tuser;
  assign s1_resp_axis_tuser = m_resp_axis_tuser;
  assign s0_resp_axis_data  = m_resp_axis_data;
  assign s1_resp_axis_data  = m_resp_axis_data;

  assign protocol_err_out   = r_prot_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus randomized traffic against a
// packet-level scoreboard and an in-order memory responder model.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned TAG_DEPTH = 4;
  localparam int unsigned BPL       = 4;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         s0_req_axis_valid, s0_req_axis_ready, s0_req_axis_tuser;
  logic [127:0] s0_req_axis_data;
  logic         s1_req_axis_valid, s1_req_axis_ready, s1_req_axis_tuser;
  logic [127:0] s1_req_axis_data;
  logic         m_req_axis_valid, m_req_axis_ready, m_req_axis_tuser;
  logic [127:0] m_req_axis_data;
  logic         m_resp_axis_valid, m_resp_axis_ready, m_resp_axis_tuser;
  logic [127:0] m_resp_axis_data;
  logic         s0_resp_axis_valid, s0_resp_axis_ready, s0_resp_axis_tuser;
  logic [127:0] s0_resp_axis_data;
  logic         s1_resp_axis_valid, s1_resp_axis_ready, s1_resp_axis_tuser;
  logic [127:0] s1_resp_axis_data;
  logic         protocol_err_out;

  mem_req_arbiter #(
    .TAG_DEPTH      (TAG_DEPTH),
    .BEATS_PER_LINE (BPL)
  ) u_dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .s0_req_axis_valid  (s0_req_axis_valid),
    .s0_req_axis_ready  (s0_req_axis_ready),
    .s0_req_axis_tuser  (s0_req_axis_tuser),
    .s0_req_axis_data   (s0_req_axis_data),
    .s1_req_axis_valid  (s1_req_axis_valid),
    .s1_req_axis_ready  (s1_req_axis_ready),
    .s1_req_axis_tuser  (s1_req_axis_tuser),
    .s1_req_axis_data   (s1_req_axis_data),
    .m_req_axis_valid   (m_req_axis_valid),
    .m_req_axis_ready   (m_req_axis_ready),
    .m_req_axis_tuser   (m_req_axis_tuser),
    .m_req_axis_data    (m_req_axis_data),
    .m_resp_axis_valid  (m_resp_axis_valid),
    .m_resp_axis_ready  (m_resp_axis_ready),
    .m_resp_axis_tuser  (m_resp_axis_tuser),
    .m_resp_axis_data   (m_resp_axis_data),
    .s0_resp_axis_valid (s0_resp_axis_valid),
    .s0_resp_axis_ready (s0_resp_axis_ready),
    .s0_resp_axis_tuser (s0_resp_axis_tuser),
    .s0_resp_axis_data  (s0_resp_axis_data),
    .s1_resp_axis_valid (s1_resp_axis_valid),
    .s1_resp_axis_ready (s1_resp_axis_ready),
    .s1_resp_axis_tuser (s1_resp_axis_tuser),
    .s1_resp_axis_data  (s1_resp_axis_data),
    .protocol_err_out   (protocol_err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state. Source queues hold {stray, tuser, data}; stray beats are malformed.
  logic [129:0] txq0[$];
  logic [129:0] txq1[$];
  logic [128:0] exp0[$];
  logic [128:0] exp1[$];
  logic [96:0]  mem_q[$];   // {requester, response payload base}
  int           hdr_src[$];
  int           hdr_cyc[$];
  bit           s_vld0, s_vld1, r_vld, exp_err, tog_rdy;
  int           rsp_k, mon_left, mon_src, outstanding, cyc, m_beats, err_pulses, first_pop_cyc;
  int           p_src, p_mrdy, p_rvld, p_srdy;

  function automatic bit roll(input int p);
    return (int'($urandom_range(99)) < p);
  endfunction

  task automatic add_pkt(input int src, input bit wr, input logic [31:0] addr);
    logic [127:0] h;
    logic [129:0] b;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[WR_BIT] = wr;
    h[64] = src[0];
    h[ADDR_MSB:0] = addr;
    if (src == 0) txq0.push_back({2'b01, h}); else txq1.push_back({2'b01, h});
    if (wr) begin
      for (int i = 0; i < int'(BPL); i++) begin
        b = {1'b0, 1'($urandom_range(1)), $urandom, $urandom, $urandom, $urandom};
        if (src == 0) txq0.push_back(b); else txq1.push_back(b);
      end
    end
  endtask

  task automatic add_stray(input int src);
    logic [129:0] b;
    b = {2'b10, $urandom, $urandom, $urandom, $urandom};
    if (src == 0) txq0.push_back(b); else txq1.push_back(b);
  endtask

  task automatic step();
    logic [129:0] b0, b1;
    logic [128:0] eb;
    logic [96:0]  rq;
    logic         hs0, hs1, mhs, rhs;
    int           fwd;
    @(negedge clk_in);
    if (!s_vld0 && txq0.size() > 0 && roll(p_src)) s_vld0 = 1'b1;
    if (!s_vld1 && txq1.size() > 0 && roll(p_src)) s_vld1 = 1'b1;
    b0 = (txq0.size() > 0) ? txq0[0] : '0;
    b1 = (txq1.size() > 0) ? txq1[0] : '0;
    s0_req_axis_valid = s_vld0;
    s0_req_axis_tuser = b0[128];
    s0_req_axis_data  = b0[127:0];
    s1_req_axis_valid = s_vld1;
    s1_req_axis_tuser = b1[128];
    s1_req_axis_data  = b1[127:0];
    m_req_axis_ready  = tog_rdy ? cyc[0] : roll(p_mrdy);
    if (!r_vld && mem_q.size() > 0 && roll(p_rvld)) r_vld = 1'b1;
    rq = (mem_q.size() > 0) ? mem_q[0] : '0;
    m_resp_axis_valid  = r_vld;
    m_resp_axis_tuser  = (rsp_k == 0);
    m_resp_axis_data   = {rq[95:0], 32'(rsp_k)};
    s0_resp_axis_ready = roll(p_srdy);
    s1_resp_axis_ready = roll(p_srdy);
    #1;
    hs0 = s0_req_axis_valid & s0_req_axis_ready;
    hs1 = s1_req_axis_valid & s1_req_axis_ready;
    mhs = m_req_axis_valid & m_req_axis_ready;
    rhs = m_resp_axis_valid & m_resp_axis_ready;

    check_val("prot_err", protocol_err_out, exp_err);
    if (protocol_err_out) err_pulses++;
    exp_err = 1'b0;
    fwd = 0;
    if (hs0) begin
      b0 = txq0.pop_front();
      s_vld0 = 1'b0;
      if (b0[129]) exp_err = 1'b1; else begin exp0.push_back(b0[128:0]); fwd++; end
    end
    if (hs1) begin
      b1 = txq1.pop_front();
      s_vld1 = 1'b0;
      if (b1[129]) exp_err = 1'b1; else begin exp1.push_back(b1[128:0]); fwd++; end
    end
    if (hs0 || hs1 || mhs) check_val("req_pass", 32'(mhs), 32'(fwd));

    if (mhs) begin
      m_beats++;
      if (mon_left == 0) begin
        check_val("hdr_tuser", m_req_axis_tuser, 1'b1);
        mon_src = int'(m_req_axis_data[64]);
        hdr_src.push_back(mon_src);
        hdr_cyc.push_back(cyc);
        if (m_req_axis_data[WR_BIT]) begin
          mon_left = BPL;
        end else begin
          check_val("tag_limit", 32'(outstanding < int'(TAG_DEPTH)), 32'd1);
          outstanding++;
          mem_q.push_back({m_req_axis_data[64], $urandom, $urandom, $urandom});
        end
      end else begin
        mon_left--;
      end
      check_val("req_q_nonempty", 32'((mon_src == 0) ? exp0.size() > 0 : exp1.size() > 0), 32'd1);
      if (mon_src == 0 && exp0.size() > 0) begin
        eb = exp0.pop_front();
        check_val("req_beat", {m_req_axis_tuser, m_req_axis_data}, eb);
      end else if (mon_src == 1 && exp1.size() > 0) begin
        eb = exp1.pop_front();
        check_val("req_beat", {m_req_axis_tuser, m_req_axis_data}, eb);
      end
    end

    if (m_resp_axis_valid || s0_resp_axis_valid || s1_resp_axis_valid) begin
      check_val("resp_route", {s1_resp_axis_valid, s0_resp_axis_valid},
                m_resp_axis_valid ? (rq[96] ? 2'b10 : 2'b01) : 2'b00);
    end
    if (m_resp_axis_valid) begin
      check_val("resp_ready", m_resp_axis_ready,
                rq[96] ? s1_resp_axis_ready : s0_resp_axis_ready);
    end
    if (rhs) begin
      check_val("resp_beat",
                rq[96] ? {s1_resp_axis_tuser, s1_resp_axis_data}
                       : {s0_resp_axis_tuser, s0_resp_axis_data},
                {(rsp_k == 0), rq[95:0], 32'(rsp_k)});
      r_vld = 1'b0;
      rsp_k++;
      if (rsp_k == int'(BPL)) begin
        rsp_k = 0;
        rq = mem_q.pop_front();
        outstanding--;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    {s0_req_axis_valid, s0_req_axis_tuser, s1_req_axis_valid, s1_req_axis_tuser} = '0;
    s0_req_axis_data = '0;
    s1_req_axis_data = '0;
    {m_req_axis_ready, m_resp_axis_valid, m_resp_axis_tuser} = '0;
    m_resp_axis_data = '0;
    {s0_resp_axis_ready, s1_resp_axis_ready} = '0;
    txq0.delete(); txq1.delete(); exp0.delete(); exp1.delete(); mem_q.delete();
    hdr_src.delete(); hdr_cyc.delete();
    {s_vld0, s_vld1, r_vld, exp_err, tog_rdy} = '0;
    rsp_k = 0; mon_left = 0; mon_src = 0; outstanding = 0; m_beats = 0; err_pulses = 0;
    first_pop_cyc = -1;
    p_src = 100; p_mrdy = 100; p_rvld = 100; p_srdy = 100;
    @(negedge clk_in);
    check_val("rst_outputs",
              {m_req_axis_valid, s0_req_axis_ready, s1_req_axis_ready, m_resp_axis_ready,
               s0_resp_axis_valid, s1_resp_axis_valid, protocol_err_out}, 7'b0);
    rst_n_in = 1'b1;
    cyc = 0;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while ((txq0.size() + txq1.size() + exp0.size() + exp1.size() + mem_q.size() > 0 ||
            mon_left != 0) && n < max_cyc) begin
      step();
      n++;
    end
    check_val("drained", 32'(txq0.size() + txq1.size() + mem_q.size() + mon_left), 32'd0);
    step();
    step();
  endtask

  initial begin
    rst_n_in = 1'b0;
    do_reset();

    // Single s0 read: one header out, four response beats to s0 only.
    add_pkt(0, 1'b0, 32'h100);
    run_until_idle(100);
    check_val("t1_hdr_cnt", hdr_src.size(), 1);
    if (hdr_src.size() >= 1) begin
      check_val("t1_src", hdr_src[0], 0);
      check_val("t1_latency", hdr_cyc[0], 1);
    end

    // Both request from reset: s0 first, one idle cycle, then s1.
    do_reset();
    add_pkt(0, 1'b0, 32'hA00);
    add_pkt(1, 1'b0, 32'hB00);
    run_until_idle(100);
    check_val("t2_hdr_cnt", hdr_src.size(), 2);
    if (hdr_src.size() >= 2) begin
      check_val("t2_first", hdr_src[0], 0);
      check_val("t2_second", hdr_src[1], 1);
      check_val("t2_gap", hdr_cyc[1] - hdr_cyc[0], 2);
    end

    // Write burst under toggling ready; s1 read waits for the whole packet.
    do_reset();
    tog_rdy = 1'b1;
    add_pkt(0, 1'b1, 32'h200);
    add_pkt(1, 1'b0, 32'h300);
    run_until_idle(200);
    tog_rdy = 1'b0;
    check_val("t3_beats", m_beats, 6);
    check_val("t3_hdr_cnt", hdr_src.size(), 2);
    if (hdr_src.size() >= 2) begin
      check_val("t3_first", hdr_src[0], 0);
      check_val("t3_second", hdr_src[1], 1);
    end

    // Five s1 reads with responses withheld: fifth header stalls on a full tag FIFO.
    do_reset();
    p_rvld = 0;
    for (int i = 0; i < 5; i++) add_pkt(1, 1'b0, 32'h1000 + 32'(i));
    repeat (30) step();
    check_val("t4_fwd_held", hdr_src.size(), TAG_DEPTH);
    check_val("t4_stall_valid", m_req_axis_valid, 1'b0);
    p_rvld = 100;
    run_until_idle(200);
    check_val("t4_fwd_all", hdr_src.size(), 5);
    if (hdr_src.size() >= 5) check_val("t4_release", hdr_cyc[4], first_pop_cyc + 1);

    // Malformed beats in idle: consumed, single pulse, nothing forwarded.
    do_reset();
    add_stray(0);
    repeat (5) step();
    check_val("t5_pulses", err_pulses, 1);
    check_val("t5_consumed", txq0.size(), 0);
    add_stray(0);
    add_stray(1);
    repeat (5) step();
    check_val("t5_both_pulses", err_pulses, 2);
    check_val("t5_fwd", m_beats, 0);

    // Reset mid-write after s0 last won: s0 must win the next tie again.
    do_reset();
    add_pkt(0, 1'b0, 32'h400);
    run_until_idle(100);
    add_pkt(0, 1'b1, 32'h500);
    repeat (3) step();
    do_reset();
    add_pkt(1, 1'b0, 32'h600);
    add_pkt(0, 1'b0, 32'h700);
    run_until_idle(100);
    check_val("t6_hdr_cnt", hdr_src.size(), 2);
    if (hdr_src.size() >= 1) check_val("t6_first", hdr_src[0], 0);

    // Randomized mixed traffic with occasional malformed beats.
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      p_src  = 30 + int'($urandom_range(70));
      p_mrdy = 30 + int'($urandom_range(70));
      p_rvld = 30 + int'($urandom_range(70));
      p_srdy = 30 + int'($urandom_range(70));
      for (int k = 0; k < 40; k++) begin
        if (roll(8)) add_stray(int'($urandom_range(1)));
        else add_pkt(int'($urandom_range(1)), roll(50), $urandom);
      end
      run_until_idle(6000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, max outstanding reads tracked (power of two, >=2).
REQ-002 SHALL have parameter BEATS_PER_LINE, default 4, 128-bit beats per 512-bit cache line.
REQ-003 SHALL have ports clk_in  in  1  sole clock, rising edge.
REQ-004 SHALL have ports rst_n_in  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports s0_req_axis_valid/ready/tuser/data  in/out/in/in  1/1/1/128  requester 0 (core) request stream.
REQ-006 SHALL have ports s1_req_axis_valid/ready/tuser/data  in/out/in/in  1/1/1/128  requester 1 request stream.
REQ-007 SHALL have ports m_req_axis_valid/ready/tuser/data  out/in/out/out  1/1/1/128  shared request stream to memory.
REQ-008 SHALL have ports m_resp_axis_valid/ready/tuser/data  in/out/in/in  1/1/1/128  shared response stream from memory.
REQ-009 SHALL have ports s0_resp_axis_valid/ready/tuser/data, s1_resp_axis_*  out/in/out/out  1/1/1/128  per-requester responses.
REQ-010 SHALL have port protocol_err_out  out  1  one-cycle pulse on dropped malformed beat.

Function
REQ-011 Packet format: header beat has tuser=1; data[127]=1 write, 0 read; data[31:0] line address.
REQ-012 Write packet = header + BEATS_PER_LINE data beats (tuser=0); read packet = header only; no response for writes.
REQ-013 Read response = BEATS_PER_LINE beats, tuser=1 on first beat only; responses return in request order.
REQ-014 Request FSM states: IDLE, BURST; owner register (0/1) and last_grant register.
REQ-015 IDLE: among requesters presenting valid&&tuser, grant round-robin (prefer !last_grant when both); register owner, go BURST next cycle; all s*_req ready=0, m_req_axis_valid=0 in IDLE.
REQ-016 IDLE: a requester presenting valid with tuser=0 SHALL be consumed (ready=1 that cycle), dropped, and protocol_err_out pulsed; if both malformed, both dropped, one pulse.
REQ-017 BURST: m_req_axis_* = owner's stream combinationally; owner ready = m_req_axis_ready, gated per REQ-019; non-owner ready=0.
REQ-018 BURST: beat counter loads BEATS_PER_LINE on write-header handshake, decrements per data-beat handshake; return to IDLE after read-header handshake or final write data beat; update last_grant=owner on exit.
REQ-019 Read-header handshake SHALL be blocked (owner ready=0, m_req_axis_valid=0) while owner FIFO full; no same-cycle pop bypass.
REQ-020 Each read-header handshake SHALL push owner id into owner FIFO (depth TAG_DEPTH).
REQ-021 Response path: FIFO empty -> m_resp_axis_ready=0, both s*_resp valid=0.
REQ-022 FIFO non-empty: head id selects destination; s<head>_resp_axis_* = m_resp_axis_* combinationally; m_resp_axis_ready = s<head>_resp_axis_ready; other requester's resp valid=0.
REQ-023 Response beat counter counts handshakes; pop FIFO on BEATS_PER_LINE-th beat, counter wraps to 0.
REQ-024 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-025 Non-header beats with tuser=1 during BURST SHALL be forwarded unchanged, not checked.
REQ-026 Zero-bubble on response path; one IDLE cycle between consecutive request packets.

Reset
REQ-027 When rst_n_in=0 at a rising edge: FSM=IDLE, owner=0, last_grant=1 (requester 0 wins first tie), both counters=0, FIFO empty, protocol_err_out=0.
REQ-028 During and after reset all valid and ready outputs SHALL be 0 until the FSM/FIFO allow otherwise; mid-packet reset abandons in-flight packets and tags without recovery.

Structure
REQ-029 Package mem_arb_pkg SHALL hold BEATS_PER_LINE default, header bit positions (WR_BIT=127, ADDR_MSB=31), FSM state typedef.
REQ-030 Owner FIFO SHALL be sub-module owner_fifo (1-bit wide, TAG_DEPTH deep, push/pop/full/empty, simultaneous push/pop).

Verification
REQ-031 Only s0 sends read header addr 0x100 -> one m_req beat data[31:0]=0x100 tuser=1; 4 resp beats delivered to s0 only; s1_resp valid never 1.
REQ-032 s0 and s1 both present read headers from reset -> s0 forwarded first, s1 next (one IDLE cycle between); responses A,B route s0 then s1.
REQ-033 s0 write header 0x200 + 4 data beats with m_req_axis_ready toggling 1/0 -> exactly 5 beats forwarded in order, s1 held off until done, no FIFO push.
REQ-034 Five back-to-back s1 reads with responses withheld -> four forwarded, fifth header stalled (m_req valid=0) until first response's 4th beat accepted.
REQ-035 s0 presents valid, tuser=0 in IDLE -> beat consumed, protocol_err_out=1 for exactly one cycle, nothing forwarded.
REQ-036 rst_n_in=0 for one cycle mid-write burst -> next cycle all valids/readies 0, FIFO empty; next s0 header granted first.
